// File: rtl/voice_mixer.sv
// voice_mixer: collects one sample per active voice each codec period, sums
// the held samples one voice per cycle, attenuates, saturates and presents
// a single mixed sample with a one-cycle ready pulse.
module voice_mixer #(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int GAIN_SHIFT   = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               mix_request,
  input  logic [NUM_VOICES-1:0]              voice_active,
  input  logic [NUM_VOICES-1:0]              voice_ready,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples,
  output logic [SAMPLE_WIDTH-1:0]            mix_sample,
  output logic                               mix_ready,
  output logic                               busy,
  output logic                               clip,
  output logic                               collect_timeout,
  output logic                               overrun
);

  // Accumulator has room for NUM_VOICES full-scale samples plus sign margin.
  localparam int ACC_W = SAMPLE_WIDTH + $clog2(NUM_VOICES) + 1;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_W = 16;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SUM     = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t                          r_state;
  state_t                          w_next_state;
  logic signed [SAMPLE_WIDTH-1:0]  r_hold [NUM_VOICES];
  logic [NUM_VOICES-1:0]           r_pending;
  logic [NUM_VOICES-1:0]           w_collect_left;
  logic                            w_timed_out;
  logic signed [ACC_W-1:0]         r_acc;
  logic [IDX_W-1:0]                r_idx;
  logic [CNT_W-1:0]                r_cnt;
  logic [SAMPLE_WIDTH-1:0]         r_mix_sample;
  logic                            r_mix_ready;
  logic                            r_clip;
  logic                            r_timeout;
  logic                            r_overrun;
  logic signed [ACC_W-1:0]         w_term;
  logic signed [ACC_W-1:0]         w_shifted;
  logic                            w_sat_hi;
  logic                            w_sat_lo;
  logic [SAMPLE_WIDTH-1:0]         w_mix_next;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; a collect exit counts as a timeout only if voices are still missing.
  always_comb begin
    w_next_state   = r_state;
    w_collect_left = r_pending & ~voice_ready;
    w_timed_out    = 1'b0;
    case (r_state)
      IDLE: begin
        if (mix_request) w_next_state = COLLECT;
      end
      COLLECT: begin
        if (w_collect_left == '0) begin
          w_next_state = SUM;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_next_state = SUM;
          w_timed_out  = 1'b1;
        end
      end
      SUM: begin
        if (r_idx == IDX_W'(NUM_VOICES - 1)) w_next_state = OUT;
      end
      OUT: begin
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Summing term, attenuation and saturation of the finished accumulator.
  always_comb begin
    w_term = '0;
    if (voice_active[r_idx])
      w_term = {{(ACC_W-SAMPLE_WIDTH){r_hold[r_idx][SAMPLE_WIDTH-1]}}, r_hold[r_idx]};
    w_shifted  = r_acc >>> GAIN_SHIFT;
    w_sat_hi   = (w_shifted > SAT_MAX);
    w_sat_lo   = (w_shifted < SAT_MIN);
    w_mix_next = w_shifted[SAMPLE_WIDTH-1:0];
    if (w_sat_hi)      w_mix_next = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    else if (w_sat_lo) w_mix_next = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  end

  // Per-voice hold registers capture every ready pulse, whatever the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VOICES; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (voice_ready[i]) r_hold[i] <= voice_samples[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
  end

  // Collect bookkeeping, sequential accumulation and registered output pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending    <= '0;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_idx        <= '0;
      r_mix_sample <= '0;
      r_mix_ready  <= 1'b0;
      r_clip       <= 1'b0;
      r_timeout    <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_mix_ready <= 1'b0;
      r_clip      <= 1'b0;
      r_timeout   <= 1'b0;
      r_overrun   <= mix_request && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (mix_request) begin
            r_pending <= voice_active & ~voice_ready;
            r_cnt     <= '0;
          end
        end
        COLLECT: begin
          r_pending <= w_collect_left;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (w_next_state == SUM) begin
            r_acc     <= '0;
            r_idx     <= '0;
            r_timeout <= w_timed_out;
          end
        end
        SUM: begin
          r_acc <= r_acc + w_term;
          r_idx <= r_idx + IDX_W'(1);
        end
        OUT: begin
          r_mix_sample <= w_mix_next;
          r_mix_ready  <= 1'b1;
          r_clip       <= w_sat_hi | w_sat_lo;
        end
        default: ;
      endcase
    end
  end

  assign mix_sample      = r_mix_sample;
  assign mix_ready       = r_mix_ready;
  assign busy            = (r_state != IDLE);
  assign clip            = r_clip;
  assign collect_timeout = r_timeout;
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed scenarios for voice_mixer. A second instance with
// no attenuation shares the stimulus so saturation can be reached.
module tb_voice_mixer;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        mixRequest = 1'b0;
  logic [3:0]  voiceActive = '0;
  logic [3:0]  voiceReady = '0;
  logic [63:0] voiceSamples = '0;

  logic [15:0] mixSample, satMixSample;
  logic        mixReady, busy, clip, collectTimeout, overrun;
  logic        satMixReady, satBusy, satClip, satCollectTimeout, satOverrun;

  int total = 0;
  int bad = 0;

  voice_mixer #(.NUM_VOICES(4), .SAMPLE_WIDTH(16), .GAIN_SHIFT(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(rstN), .mix_request(mixRequest), .voice_active(voiceActive),
    .voice_ready(voiceReady), .voice_samples(voiceSamples), .mix_sample(mixSample),
    .mix_ready(mixReady), .busy(busy), .clip(clip), .collect_timeout(collectTimeout),
    .overrun(overrun)
  );

  voice_mixer #(.NUM_VOICES(4), .SAMPLE_WIDTH(16), .GAIN_SHIFT(0), .TIMEOUT(16)) dutSat (
    .clk(clk), .reset(rstN), .mix_request(mixRequest), .voice_active(voiceActive),
    .voice_ready(voiceReady), .voice_samples(voiceSamples), .mix_sample(satMixSample),
    .mix_ready(satMixReady), .busy(satBusy), .clip(satClip),
    .collect_timeout(satCollectTimeout), .overrun(satOverrun)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setSample(input int v, input logic [15:0] s);
    voiceSamples[v*16 +: 16] = s;
  endtask

  // Wait (bounded) for mix_ready; returns cycles elapsed, 0 if it never came.
  task automatic waitReady(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mixReady === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Issue a request with every active voice reporting on the same cycle.
  task automatic requestWithReady(input logic [3:0] readyMask);
    mixRequest = 1'b1;
    voiceReady = readyMask;
    tick();
    mixRequest = 1'b0;
    voiceReady = '0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    tick();
    tick();
    total++; if (mixSample !== 16'h0) begin bad++; $display("[TB] FAIL reset_mix_sample actual=%h required=0000", mixSample); end
    total++; if (mixReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_mix_ready actual=%b required=0", mixReady); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy actual=%b required=0", busy); end
    total++; if ({clip, collectTimeout, overrun} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags actual=%b required=000", {clip, collectTimeout, overrun}); end
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_basic_mix();
    int cycles;
    voiceActive = 4'b0111;
    setSample(0, 16'd1000);
    setSample(1, 16'd2000);
    setSample(2, -16'sd500);
    setSample(3, 16'd0);
    mixRequest = 1'b1;
    tick();
    mixRequest = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy actual=%b required=1", busy); end
    tick();
    voiceReady = 4'b0111;
    tick();
    voiceReady = '0;
    waitReady(cycles);
    total++; if (cycles != 5) begin bad++; $display("[TB] FAIL basic_latency actual=%0d required=5", cycles); end
    total++; if (mixSample !== 16'd625) begin bad++; $display("[TB] FAIL basic_sample actual=%0d required=625", $signed(mixSample)); end
    total++; if (clip !== 1'b0) begin bad++; $display("[TB] FAIL basic_clip actual=%b required=0", clip); end
    total++; if (satMixSample !== 16'd2500) begin bad++; $display("[TB] FAIL basic_noshift_sample actual=%0d required=2500", $signed(satMixSample)); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_idle_after actual=%b required=0", busy); end
  endtask

  task automatic test_saturation();
    int cycles;
    voiceActive = 4'b1111;
    for (int v = 0; v < 4; v++) setSample(v, 16'h7FFF);
    requestWithReady(4'b1111);
    waitReady(cycles);
    total++; if (cycles != 6) begin bad++; $display("[TB] FAIL sat_pos_latency actual=%0d required=6", cycles); end
    total++; if (satMixSample !== 16'h7FFF) begin bad++; $display("[TB] FAIL sat_pos_sample actual=%h required=7fff", satMixSample); end
    total++; if (satClip !== 1'b1) begin bad++; $display("[TB] FAIL sat_pos_clip actual=%b required=1", satClip); end
    total++; if (mixSample !== 16'h7FFF || clip !== 1'b0) begin bad++; $display("[TB] FAIL sat_pos_shifted actual=%h/%b required=7fff/0", mixSample, clip); end
    tick();
    for (int v = 0; v < 4; v++) setSample(v, 16'h8000);
    requestWithReady(4'b1111);
    waitReady(cycles);
    total++; if (satMixSample !== 16'h8000) begin bad++; $display("[TB] FAIL sat_neg_sample actual=%h required=8000", satMixSample); end
    total++; if (satClip !== 1'b1) begin bad++; $display("[TB] FAIL sat_neg_clip actual=%b required=1", satClip); end
    total++; if (mixSample !== 16'h8000 || clip !== 1'b0) begin bad++; $display("[TB] FAIL sat_neg_shifted actual=%h/%b required=8000/0", mixSample, clip); end
    tick();
    total++; if (satClip !== 1'b0) begin bad++; $display("[TB] FAIL sat_clip_pulse actual=%b required=0", satClip); end
  endtask

  task automatic test_timeout();
    int toCycle = 0;
    int rdyCycle = 0;
    int toPulses = 0;
    for (int v = 0; v < 4; v++) setSample(v, 16'd0);
    setSample(2, 16'd400);
    voiceReady = 4'b0100;
    tick();
    voiceReady = '0;
    setSample(2, 16'd9999);
    voiceActive = 4'b0100;
    mixRequest = 1'b1;
    tick();
    mixRequest = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (collectTimeout === 1'b1) begin
        toPulses++;
        if (toCycle == 0) toCycle = i;
      end
      if (mixReady === 1'b1) begin
        rdyCycle = i;
        break;
      end
    end
    total++; if (toCycle != 16) begin bad++; $display("[TB] FAIL timeout_cycle actual=%0d required=16", toCycle); end
    total++; if (toPulses != 1) begin bad++; $display("[TB] FAIL timeout_pulses actual=%0d required=1", toPulses); end
    total++; if (rdyCycle != 21) begin bad++; $display("[TB] FAIL timeout_ready_cycle actual=%0d required=21", rdyCycle); end
    total++; if (mixSample !== 16'd100) begin bad++; $display("[TB] FAIL timeout_sample actual=%0d required=100", $signed(mixSample)); end
  endtask

  task automatic test_overrun();
    int ovPulses = 0;
    int rdyPulses = 0;
    logic [15:0] gotSample = '0;
    voiceActive = 4'b0011;
    setSample(0, 16'd400);
    setSample(1, 16'd800);
    requestWithReady(4'b0011);
    tick();
    tick();
    mixRequest = 1'b1;
    tick();
    mixRequest = 1'b0;
    setSample(0, 16'd7000);
    if (overrun === 1'b1) ovPulses++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (overrun === 1'b1) ovPulses++;
      if (mixReady === 1'b1) begin
        rdyPulses++;
        gotSample = mixSample;
      end
    end
    total++; if (ovPulses != 1) begin bad++; $display("[TB] FAIL overrun_pulses actual=%0d required=1", ovPulses); end
    total++; if (rdyPulses != 1) begin bad++; $display("[TB] FAIL overrun_ready_pulses actual=%0d required=1", rdyPulses); end
    total++; if (gotSample !== 16'd300) begin bad++; $display("[TB] FAIL overrun_sample actual=%0d required=300", $signed(gotSample)); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL overrun_idle actual=%b required=0", busy); end
  endtask

  task automatic test_back_to_back();
    int rdyPulses = 0;
    voiceActive = 4'b0001;
    setSample(0, -16'sd3);
    requestWithReady(4'b0001);
    for (int i = 0; i < 5; i++) tick();
    mixRequest = 1'b1;
    tick();
    mixRequest = 1'b0;
    total++; if (mixReady !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready actual=%b required=1", mixReady); end
    total++; if (mixSample !== 16'hFFFF) begin bad++; $display("[TB] FAIL b2b_floor_sample actual=%0d required=-1", $signed(mixSample)); end
    total++; if (satMixSample !== 16'hFFFD) begin bad++; $display("[TB] FAIL b2b_noshift_sample actual=%0d required=-3", $signed(satMixSample)); end
    total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL b2b_overrun actual=%b required=1", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_busy actual=%b required=0", busy); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mixReady === 1'b1 || busy === 1'b1) rdyPulses++;
    end
    total++; if (rdyPulses != 0) begin bad++; $display("[TB] FAIL b2b_dropped actual=%0d required=0", rdyPulses); end
  endtask

  task automatic test_empty_mix();
    int cycles;
    voiceActive = 4'b0000;
    mixRequest = 1'b1;
    tick();
    mixRequest = 1'b0;
    waitReady(cycles);
    total++; if (cycles != 6) begin bad++; $display("[TB] FAIL empty_latency actual=%0d required=6", cycles); end
    total++; if (mixSample !== 16'd0) begin bad++; $display("[TB] FAIL empty_sample actual=%0d required=0", $signed(mixSample)); end
    tick();
    voiceActive = 4'b0010;
    setSample(1, 16'd1200);
    requestWithReady(4'b0010);
    total++; if (collectTimeout !== 1'b0) begin bad++; $display("[TB] FAIL same_cycle_timeout actual=%b required=0", collectTimeout); end
    waitReady(cycles);
    total++; if (cycles != 6) begin bad++; $display("[TB] FAIL same_cycle_latency actual=%0d required=6", cycles); end
    total++; if (mixSample !== 16'd300) begin bad++; $display("[TB] FAIL same_cycle_sample actual=%0d required=300", $signed(mixSample)); end
  endtask

  task automatic test_reset_mid_sum();
    int cycles;
    voiceActive = 4'b0011;
    setSample(0, 16'd400);
    setSample(1, 16'd800);
    requestWithReady(4'b0011);
    tick();
    tick();
    #2;
    rstN = 1'b0;
    #1;
    total++; if (mixSample !== 16'h0) begin bad++; $display("[TB] FAIL midsum_sample actual=%h required=0000", mixSample); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midsum_busy actual=%b required=0", busy); end
    total++; if ({mixReady, clip, collectTimeout, overrun} !== 4'b0000) begin bad++; $display("[TB] FAIL midsum_flags actual=%b required=0000", {mixReady, clip, collectTimeout, overrun}); end
    #2;
    rstN = 1'b1;
    tick();
    voiceActive = 4'b0111;
    setSample(0, 16'd1000);
    setSample(1, 16'd2000);
    setSample(2, -16'sd500);
    requestWithReady(4'b0111);
    waitReady(cycles);
    total++; if (cycles != 6) begin bad++; $display("[TB] FAIL after_reset_latency actual=%0d required=6", cycles); end
    total++; if (mixSample !== 16'd625) begin bad++; $display("[TB] FAIL after_reset_sample actual=%0d required=625", $signed(mixSample)); end
  endtask

  initial begin
    test_reset();
    test_basic_mix();
    test_saturation();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_empty_mix();
    test_reset_mid_sum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
